// File: rtl/zstr_pack.sv
// zstr width up-converter: packs N BW-bit words into one BW*N-bit word.
// Define ZSTR_PACK_LAST_EN to add early group close (zi_lst/zo_lst/zo_cnt).
module zstr_pack #(
  parameter int BW = 8,
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            z_clk,
  input  logic            z_rst,
  input  logic            zi_vld,
  input  logic [BW-1:0]   zi_bus,
  output logic            zi_ack,
`ifdef ZSTR_PACK_LAST_EN
  input  logic            zi_lst,
  output logic            zo_lst,
  output logic [CW-1:0]   zo_cnt,
`endif
  output logic            zo_vld,
  output logic [BW*N-1:0] zo_bus,
  input  logic            zo_ack
);

  // N=1 keeps a dummy lane so acc never has zero width
  localparam int AW = (N > 1) ? BW * (N - 1) : BW;

  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [BW*N-1:0] pk;
  logic            last;
  logic            close;
  logic            in_xfer;
  logic            out_xfer;
  logic            load;

  assign last = (cnt == CW'(N - 1));

`ifdef ZSTR_PACK_LAST_EN
  assign close = last | zi_lst;
`else
  assign close = last;
`endif

  assign zi_ack   = ~close | ~zo_vld | zo_ack;
  assign in_xfer  = zi_vld & zi_ack;
  assign out_xfer = zo_vld & zo_ack;
  assign load     = in_xfer & close;

  // lanes below cnt from acc, current word at cnt, zero above
  always_comb begin
    pk = '0;
    for (int k = 0; k < N - 1; k++)
      if (CW'(k) < cnt)
        pk[BW*k +: BW] = acc[BW*k +: BW];
    for (int k = 0; k < N; k++)
      if (cnt == CW'(k))
        pk[BW*k +: BW] = zi_bus;
  end

  always_ff @(posedge z_clk or negedge z_rst) begin
    if (!z_rst) begin
      cnt    <= '0;
      acc    <= '0;
      zo_vld <= 1'b0;
      zo_bus <= '0;
`ifdef ZSTR_PACK_LAST_EN
      zo_lst <= 1'b0;
      zo_cnt <= '0;
`endif
    end else begin
      if (in_xfer) begin
        cnt <= close ? '0 : cnt + 1'b1;
        if (!close)
          for (int k = 0; k < N - 1; k++)
            if (cnt == CW'(k))
              acc[BW*k +: BW] <= zi_bus;
      end
      if (load) begin
        zo_vld <= 1'b1;
        zo_bus <= pk;
`ifdef ZSTR_PACK_LAST_EN
        zo_lst <= zi_lst;
        zo_cnt <= cnt + 1'b1;
`endif
      end else if (out_xfer) begin
        zo_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zstr_pack.sv
// Self-checking bench for zstr_pack: queue-based group model plus
// directed vectors with literal expectations.
module tb_zstr_pack;

  localparam int BW = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic            z_clk = 1'b0;
  logic            z_rst = 1'b0;
  logic            zi_vld = 1'b0;
  logic [BW-1:0]   zi_bus = '0;
  logic            zi_ack;
  logic            zo_vld;
  logic [BW*N-1:0] zo_bus;
  logic            zo_ack = 1'b0;
`ifdef ZSTR_PACK_LAST_EN
  logic            zi_lst = 1'b0;
  logic            zo_lst;
  logic [CW-1:0]   zo_cnt;
`endif

  zstr_pack #(.BW(BW), .N(N), .CW(CW)) dut (
    .z_clk  (z_clk),
    .z_rst  (z_rst),
    .zi_vld (zi_vld),
    .zi_bus (zi_bus),
    .zi_ack (zi_ack),
`ifdef ZSTR_PACK_LAST_EN
    .zi_lst (zi_lst),
    .zo_lst (zo_lst),
    .zo_cnt (zo_cnt),
`endif
    .zo_vld (zo_vld),
    .zo_bus (zo_bus),
    .zo_ack (zo_ack)
  );

  always #5 z_clk = ~z_clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: pending group as a word queue, output as a value/valid pair
  logic [BW-1:0]   grp[$];
  logic            m_vld = 1'b0;
  logic [BW*N-1:0] m_bus = '0;
  logic [31:0]     m_cnt = '0;
  logic            m_lst = 1'b0;
  logic [31:0]     got[$];

  function automatic logic m_ack();
    logic blk;
    blk = (grp.size() == N - 1);
`ifdef ZSTR_PACK_LAST_EN
    blk = blk | zi_lst;
`endif
    return !blk || !m_vld || zo_ack;
  endfunction

  function automatic logic [31:0] pick(input int i);
    return (i < got.size()) ? got[i] : 32'hDEAD_BEEF;
  endfunction

  always @(posedge z_clk or negedge z_rst) begin : model
    logic a, cl, ld, ot;
    logic [BW*N-1:0] b;
    if (!z_rst) begin
      grp.delete();
      m_vld = 1'b0;
      m_bus = '0;
      m_cnt = 0;
      m_lst = 1'b0;
    end else begin
      a  = m_ack();
      ot = m_vld && zo_ack;
      ld = 1'b0;
      if (ot) got.push_back(m_bus);
      if (zi_vld && a) begin
        grp.push_back(zi_bus);
        cl = (grp.size() == N);
`ifdef ZSTR_PACK_LAST_EN
        cl = cl | zi_lst;
`endif
        if (cl) begin
          b = '0;
          foreach (grp[k]) b[BW*k +: BW] = grp[k];
          m_bus = b;
          m_cnt = grp.size();
`ifdef ZSTR_PACK_LAST_EN
          m_lst = zi_lst;
`endif
          grp.delete();
          ld = 1'b1;
        end
      end
      if (ld) m_vld = 1'b1;
      else if (ot) m_vld = 1'b0;
    end
  end

  always @(negedge z_clk) begin
    chk("zi_ack", zi_ack, m_ack());
    chk("zo_vld", zo_vld, m_vld);
    chk("zo_bus", zo_bus, m_bus);
`ifdef ZSTR_PACK_LAST_EN
    chk("zo_lst", zo_lst, m_lst);
    chk("zo_cnt", zo_cnt, m_cnt[CW-1:0]);
`endif
  end

  bit fr_mode = 1'b0;
  int ack_drop = 0;
  int vld_cyc  = 0;
  always @(negedge z_clk)
    if (fr_mode) begin
      if (zi_ack !== 1'b1) ack_drop++;
      if (zo_vld === 1'b1) vld_cyc++;
    end

  task automatic step();
    @(posedge z_clk);
    #1;
  endtask

  task automatic send(input logic [BW-1:0] w, input bit rnd);
    bit ok;
    ok = 1'b0;
    zi_vld = 1'b1;
    zi_bus = w;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge z_clk);
      ok = zi_ack;
      step();
      if (rnd) zo_ack = 1'($urandom_range(0, 1));
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: word %0h never accepted", w);
    end
  endtask

  task automatic idle(input int n, input bit rnd);
    zi_vld = 1'b0;
    for (int i = 0; i < n; i++) begin
      zi_bus = BW'($urandom);
      step();
      if (rnd) zo_ack = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge z_clk);
    @(negedge z_clk);
    chk("rst_vld", zo_vld, 1'b0);
    chk("rst_bus", zo_bus, 32'h0);
    chk("rst_ack", zi_ack, 1'b1);
    step();
    z_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      zi_bus = BW'($urandom);
      @(negedge z_clk);
      chk("idle_vld", zo_vld, 1'b0);
      step();
    end

    // full rate
    got.delete();
    zo_ack  = 1'b1;
    fr_mode = 1'b1;
    for (int w = 0; w < 8; w++) send(BW'(w), 1'b0);
    idle(3, 1'b0);
    fr_mode = 1'b0;
    chk("fr_count", got.size(), 2);
    chk("fr_w0", pick(0), 32'h0302_0100);
    chk("fr_w1", pick(1), 32'h0706_0504);
    chk("fr_ack_drops", ack_drop, 0);
    chk("fr_vld_cycles", vld_cyc, 2);

    // backpressure
    got.delete();
    zo_ack = 1'b0;
    for (int w = 0; w < 7; w++) send(BW'(w), 1'b0);
    zi_bus = 8'h07;
    for (int i = 0; i < 3; i++) begin
      @(negedge z_clk);
      chk("bp_ack_low", zi_ack, 1'b0);
      chk("bp_hold_vld", zo_vld, 1'b1);
      chk("bp_hold_bus", zo_bus, 32'h0302_0100);
      step();
    end
    zo_ack = 1'b1;
    @(negedge z_clk);
    chk("bp_ack_high", zi_ack, 1'b1);
    step();
    zo_ack = 1'b0;
    zi_vld = 1'b0;
    @(negedge z_clk);
    chk("bp_swap_vld", zo_vld, 1'b1);
    chk("bp_swap_bus", zo_bus, 32'h0706_0504);
    step();
    zo_ack = 1'b1;
    idle(2, 1'b0);
    chk("bp_count", got.size(), 2);
    chk("bp_w0", pick(0), 32'h0302_0100);
    chk("bp_w1", pick(1), 32'h0706_0504);

    // random gaps
    got.delete();
    for (int w = 0; w < 19; w++) begin
      idle($urandom_range(0, 2), 1'b1);
      send(BW'(w), 1'b1);
    end
    zo_ack = 1'b1;
    idle(3, 1'b0);
    chk("rg_count", got.size(), 4);
    chk("rg_w0", pick(0), 32'h0302_0100);
    chk("rg_w1", pick(1), 32'h0706_0504);
    chk("rg_w2", pick(2), 32'h0B0A_0908);
    chk("rg_w3", pick(3), 32'h0F0E_0D0C);
    send(8'h13, 1'b0);
    idle(2, 1'b0);
    chk("rg_tail_count", got.size(), 5);
    chk("rg_tail", pick(4), 32'h1312_1110);

    // reset mid-group with a pending output word
    got.delete();
    zo_ack = 1'b0;
    for (int w = 0; w < 4; w++) send(8'hC0 + BW'(w), 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    zi_vld = 1'b0;
    z_rst  = 1'b0;
    @(negedge z_clk);
    chk("mr_vld", zo_vld, 1'b0);
    chk("mr_ack", zi_ack, 1'b1);
    step();
    z_rst  = 1'b1;
    zo_ack = 1'b1;
    step();
    for (int w = 0; w < 4; w++) send(8'h10 + BW'(w), 1'b0);
    idle(2, 1'b0);
    chk("mr_count", got.size(), 1);
    chk("mr_w0", pick(0), 32'h1312_1110);

`ifdef ZSTR_PACK_LAST_EN
    got.delete();
    zo_ack = 1'b1;
    zi_lst = 1'b0;
    send(8'hA0, 1'b0);
    zi_lst = 1'b1;
    send(8'hA1, 1'b0);
    zi_lst = 1'b0;
    zi_vld = 1'b0;
    zo_ack = 1'b0;
    @(negedge z_clk);
    chk("lst_bus", zo_bus, 32'h0000_A1A0);
    chk("lst_cnt", zo_cnt, 2);
    chk("lst_flag", zo_lst, 1'b1);
    step();
    zo_ack = 1'b1;
    for (int w = 0; w < 4; w++) send(8'hB0 + BW'(w), 1'b0);
    idle(2, 1'b0);
    chk("lst_count", got.size(), 2);
    chk("lst_w1", pick(1), 32'hB3B2_B1B0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
